hsst_rx_deframer: RTL

Receive-side counterpart of the Ethernet-to-HSST bridge, sitting directly downstream of the HSST lane 3 receiver. It word-aligns the 32-bit 8b/10b decoded stream on the K28.5 idle word (32'hff_00_00_bc, K=4'b0001) and qualifies link lock. It then extracts fixed-length data packets (runs of non-K words between idles) and presents them with start/end markers, plus packet and error counters, to the downstream buffer that feeds the UDP transmit path.

---
 rtl/hsst_rx_deframer_if.sv | 28 ++
 rtl/hsst_rx_deframer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hsst_rx_deframer_if.sv
// Deframer bus: raw lane-3 receive inputs and the aligned packet stream with its status.
// The master is the deframer; the slave is the lane driver plus the packet consumer.
interface hsst_rx_deframer_if;
    logic        rx_ready;
    logic [31:0] hsst_rxd3;
    logic [3:0]  hsst_rxk3;
    logic        link_lock;
    logic [31:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_sop;
    logic        pkt_eop;
    logic        pkt_done;
    logic        pkt_err;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    modport master (
        input  rx_ready, hsst_rxd3, hsst_rxk3,
        output link_lock, pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_done, pkt_err,
               pkt_cnt, err_cnt
    );

    modport slave (
        output rx_ready, hsst_rxd3, hsst_rxk3,
        input  link_lock, pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_done, pkt_err,
               pkt_cnt, err_cnt
    );
endinterface

// File: rtl/hsst_rx_deframer.sv
// HSST lane-3 receive deframer: K28.5 word alignment, lock qualification and
// fixed-length packet extraction with packet/error counters.
module hsst_rx_deframer #(
    parameter int PKT_WORDS  = 128,
    parameter int LOCK_IDLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hsst_rx_deframer_if.master   bus
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_DATA   = 2'd1;
    localparam logic [1:0]  ST_GAP    = 2'd2;
    localparam logic [31:0] IDLE_WORD = 32'hff00_00bc;
    localparam int          IW        = $clog2(LOCK_IDLES + 1);
    localparam logic [IW-1:0] LOCK_N  = IW'(LOCK_IDLES);
    localparam logic [IW-1:0] LOCK_M1 = IW'(LOCK_IDLES - 1);
    localparam logic [8:0]  LAST_M1   = 9'(PKT_WORDS - 1);

    logic [31:0]   prev_d;
    logic [3:0]    prev_k;
    logic [1:0]    align_sel;
    logic [1:0]    state;
    logic [IW-1:0] idle_cnt;
    logic [8:0]    word_cnt;
    logic          ovr_seen;

    logic          link_lock_q;
    logic [31:0]   pkt_data_q;
    logic          pkt_vld_q, pkt_sop_q, pkt_eop_q, pkt_done_q, pkt_err_q;
    logic [15:0]   pkt_cnt_q;
    logic [7:0]    err_cnt_q;

    logic          comma_hit;
    logic [1:0]    comma_pos;
    logic [55:0]   raw_cat;
    logic [6:0]    rawk_cat;
    logic [31:0]   al_d;
    logic [3:0]    al_k;
    logic          al_idle;
    logic          realign;

    always_comb begin
        comma_hit = 1'b0;
        comma_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.hsst_rxk3 == (4'b0001 << i) && bus.hsst_rxd3[8*i +: 8] == 8'hbc) begin
                comma_hit = 1'b1;
                comma_pos = 2'(i);
            end
        end
    end

    // Byte offset 3 is the widest shift, so only the low three bytes of the new word are needed.
    assign raw_cat  = {bus.hsst_rxd3[23:0], prev_d};
    assign rawk_cat = {bus.hsst_rxk3[2:0], prev_k};
    assign al_d     = raw_cat[{align_sel, 3'b000} +: 32];
    assign al_k     = rawk_cat[align_sel +: 4];
    assign al_idle  = (al_d == IDLE_WORD) && (al_k == 4'b0001);
    assign realign  = (state == ST_IDLE) && comma_hit && (comma_pos != align_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_d      <= '0;
            prev_k      <= '0;
            align_sel   <= '0;
            idle_cnt    <= '0;
            link_lock_q <= 1'b0;
        end else begin
            prev_d <= bus.hsst_rxd3;
            prev_k <= bus.hsst_rxk3;
            if (!bus.rx_ready) begin
                idle_cnt    <= '0;
                link_lock_q <= 1'b0;
            end else if (realign) begin
                align_sel   <= comma_pos;
                idle_cnt    <= '0;
                link_lock_q <= 1'b0;
            end else if (al_idle) begin
                if (idle_cnt != LOCK_N)
                    idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt >= LOCK_M1)
                    link_lock_q <= 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            ovr_seen   <= 1'b0;
            pkt_data_q <= '0;
            pkt_vld_q  <= 1'b0;
            pkt_sop_q  <= 1'b0;
            pkt_eop_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            pkt_vld_q  <= 1'b0;
            pkt_sop_q  <= 1'b0;
            pkt_eop_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            if (!bus.rx_ready) begin
                // Lane drop abandons any open packet silently.
                state    <= ST_IDLE;
                word_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (al_k == 4'b0000 && link_lock_q) begin
                            pkt_data_q <= al_d;
                            pkt_vld_q  <= 1'b1;
                            pkt_sop_q  <= 1'b1;
                            word_cnt   <= 9'd1;
                            state      <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (al_k == 4'b0000) begin
                            pkt_data_q <= al_d;
                            pkt_vld_q  <= 1'b1;
                            word_cnt   <= word_cnt + 9'd1;
                            if (word_cnt == LAST_M1) begin
                                pkt_eop_q  <= 1'b1;
                                pkt_done_q <= 1'b1;
                                pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                                ovr_seen   <= 1'b0;
                                state      <= ST_GAP;
                            end
                        end else begin
                            pkt_err_q <= 1'b1;
                            if (err_cnt_q != 8'hff)
                                err_cnt_q <= err_cnt_q + 8'd1;
                            word_cnt <= '0;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (al_k != 4'b0000) begin
                            word_cnt <= '0;
                            state    <= ST_IDLE;
                        end else if (!ovr_seen) begin
                            // Overrun is reported once per gap, further words drop quietly.
                            ovr_seen  <= 1'b1;
                            pkt_err_q <= 1'b1;
                            if (err_cnt_q != 8'hff)
                                err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.link_lock = link_lock_q;
    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_vld   = pkt_vld_q;
    assign bus.pkt_sop   = pkt_sop_q;
    assign bus.pkt_eop   = pkt_eop_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
